// File: rtl/mem_bus_pkg.sv
// Shared definitions for the memory bus arbiter: access mode encodings and default widths.
package mem_bus_pkg;

  typedef enum logic [1:0] {
    MODE_IDLE = 2'd0,
    MODE_BYTE = 2'd1,
    MODE_HALF = 2'd2,
    MODE_WORD = 2'd3
  } mem_mode_e;

  localparam int DEF_N        = 4;
  localparam int DEF_DW       = 32;
  localparam int DEF_AW       = 32;
  localparam int DEF_MW       = 2;
  localparam int DEF_MAX_HOLD = 16;

  // Pointer width that stays legal even for a degenerate single-master build
  function automatic int ptrWidth(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/mem_bus_arbiter_rr_pick.sv
// Combinational round-robin picker: first requester strictly after i_ptr, wrapping, wins.
module rr_pick
  import mem_bus_pkg::*;
#(
  parameter int N = DEF_N
) (
  input  logic [N-1:0]           i_req,
  input  logic [ptrWidth(N)-1:0] i_ptr,
  output logic [N-1:0]           o_gnt,
  output logic [ptrWidth(N)-1:0] o_idx,
  output logic                   o_valid
);

  localparam int PW = ptrWidth(N);

  logic [PW-1:0] w_cand;

  always_comb begin
    o_gnt   = '0;
    o_idx   = i_ptr;
    o_valid = 1'b0;
    w_cand  = '0;
    for (int k = 1; k <= N; k++) begin
      w_cand = PW'((int'(i_ptr) + k) % N);
      if (!o_valid && i_req[w_cand]) begin
        o_valid       = 1'b1;
        o_gnt[w_cand] = 1'b1;
        o_idx         = w_cand;
      end
    end
  end

endmodule

// File: rtl/mem_bus_arbiter.sv
// Round-robin arbiter and AND-OR bus mux sharing one data memory among N masters.
// Define MEM_ARB_TIMEOUT_EN to revoke a grant held MAX_HOLD cycles while others wait.
module mem_bus_arbiter
  import mem_bus_pkg::*;
#(
  parameter int N        = DEF_N,
  parameter int DW       = DEF_DW,
  parameter int AW       = DEF_AW,
  parameter int MW       = DEF_MW,
  parameter int MAX_HOLD = DEF_MAX_HOLD
) (
  input  logic            i_clk,
  input  logic            i_rst,
  input  logic [N-1:0]    i_req,
  input  logic [N*AW-1:0] i_m_addr,
  input  logic [N*DW-1:0] i_m_wdata,
  input  logic [N*MW-1:0] i_m_wdm,
  input  logic [N*MW-1:0] i_m_rdm,
  output logic [N-1:0]    o_grt,
  output logic [DW-1:0]   o_m_rdata,
  output logic [AW-1:0]   o_mem_addr,
  output logic [DW-1:0]   o_mem_wdata,
  output logic [MW-1:0]   o_mem_wdm,
  output logic [MW-1:0]   o_mem_rdm,
  input  logic [DW-1:0]   i_mem_rdata,
  output logic            o_busy
);

  localparam int PW = ptrWidth(N);

  if (N < 2 || N > 8 || MAX_HOLD < 1) begin : g_badParam
    $error("mem_bus_arbiter: N must be 2..8 and MAX_HOLD at least 1");
  end

  logic [N-1:0]  r_grt;
  logic [PW-1:0] r_ptr;
  logic [N-1:0]  w_grtNxt;
  logic [PW-1:0] w_ptrNxt;
  logic [N-1:0]  w_pickGnt;
  logic [PW-1:0] w_pickIdx;
  logic          w_pickValid;
  logic          w_ownerKeep;
  logic          w_revoke;
  logic [N-1:0]  w_sel;

`ifdef MEM_ARB_TIMEOUT_EN
  localparam int HW = $clog2(MAX_HOLD + 1);
  logic [HW-1:0] r_hold;
  logic [HW-1:0] w_holdNxt;
`endif

  rr_pick #(.N(N)) u_pick (
    .i_req   (i_req),
    .i_ptr   (r_ptr),
    .o_gnt   (w_pickGnt),
    .o_idx   (w_pickIdx),
    .o_valid (w_pickValid)
  );

  // r_ptr always names the current owner, so the owner's request is i_req[r_ptr]
  always_comb begin
    w_grtNxt    = r_grt;
    w_ptrNxt    = r_ptr;
    w_ownerKeep = (|r_grt) && i_req[r_ptr];
    w_revoke    = 1'b0;
`ifdef MEM_ARB_TIMEOUT_EN
    w_holdNxt = r_hold;
    w_revoke  = w_ownerKeep && (r_hold >= HW'(MAX_HOLD)) && (|(i_req & ~r_grt));
`endif
    if (w_revoke) begin
      w_grtNxt = '0;
`ifdef MEM_ARB_TIMEOUT_EN
      w_holdNxt = '0;
`endif
    end else if (w_ownerKeep) begin
`ifdef MEM_ARB_TIMEOUT_EN
      if (r_hold != HW'(MAX_HOLD)) w_holdNxt = r_hold + HW'(1);
`endif
    end else begin
      w_grtNxt = w_pickGnt;
      if (w_pickValid) w_ptrNxt = w_pickIdx;
`ifdef MEM_ARB_TIMEOUT_EN
      w_holdNxt = w_pickValid ? HW'(1) : '0;
`endif
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_grt <= '0;
      r_ptr <= PW'(N - 1);
    end else begin
      r_grt <= w_grtNxt;
      r_ptr <= w_ptrNxt;
    end
  end

`ifdef MEM_ARB_TIMEOUT_EN
  always_ff @(posedge i_clk) begin
    if (i_rst) r_hold <= '0;
    else       r_hold <= w_holdNxt;
  end
`endif

  // Reset suppresses the mux so no access leaks out during the reset cycle
  assign w_sel = i_rst ? '0 : r_grt;

  always_comb begin
    o_mem_addr  = '0;
    o_mem_wdata = '0;
    o_mem_wdm   = MW'(MODE_IDLE);
    o_mem_rdm   = MW'(MODE_IDLE);
    for (int i = 0; i < N; i++) begin
      o_mem_addr  = o_mem_addr  | ({AW{w_sel[i]}} & i_m_addr[i*AW +: AW]);
      o_mem_wdata = o_mem_wdata | ({DW{w_sel[i]}} & i_m_wdata[i*DW +: DW]);
      o_mem_wdm   = o_mem_wdm   | ({MW{w_sel[i]}} & i_m_wdm[i*MW +: MW]);
      o_mem_rdm   = o_mem_rdm   | ({MW{w_sel[i]}} & i_m_rdm[i*MW +: MW]);
    end
  end

  assign o_grt     = r_grt;
  assign o_busy    = |r_grt;
  assign o_m_rdata = i_mem_rdata;

endmodule

// File: tb/tb_mem_bus_arbiter.sv
// Directed bench for mem_bus_arbiter: vector table plus hand-written timeout/hold sequences.
module tb_mem_bus_arbiter;

  localparam int N        = 4;
  localparam int DW       = 32;
  localparam int AW       = 32;
  localparam int MW       = 2;
  localparam int MAX_HOLD = 4;

  logic            clk = 1'b0;
  logic            rst;
  logic [N-1:0]    req;
  logic [N*AW-1:0] mAddr;
  logic [N*DW-1:0] mWdata;
  logic [N*MW-1:0] mWdm;
  logic [N*MW-1:0] mRdm;
  logic [N-1:0]    grt;
  logic [DW-1:0]   mRdata;
  logic [AW-1:0]   memAddr;
  logic [DW-1:0]   memWdata;
  logic [MW-1:0]   memWdm;
  logic [MW-1:0]   memRdm;
  logic [DW-1:0]   memRdata;
  logic            busy;

  int nChecks = 0;
  int nFails  = 0;

  logic [AW-1:0] refAddr  [N];
  logic [DW-1:0] refWdata [N];
  logic [MW-1:0] refWdm   [N];
  logic [MW-1:0] refRdm   [N];

  typedef struct {
    logic         rst;
    logic [N-1:0] req;
    logic [N-1:0] expGrt;
  } vec_t;

  vec_t vecs [23];

  always #5 clk = ~clk;

  mem_bus_arbiter #(.N(N), .DW(DW), .AW(AW), .MW(MW), .MAX_HOLD(MAX_HOLD)) dut (
    .i_clk       (clk),
    .i_rst       (rst),
    .i_req       (req),
    .i_m_addr    (mAddr),
    .i_m_wdata   (mWdata),
    .i_m_wdm     (mWdm),
    .i_m_rdm     (mRdm),
    .o_grt       (grt),
    .o_m_rdata   (mRdata),
    .o_mem_addr  (memAddr),
    .o_mem_wdata (memWdata),
    .o_mem_wdm   (memWdm),
    .o_mem_rdm   (memRdm),
    .i_mem_rdata (memRdata),
    .o_busy      (busy)
  );

  // Grant must never have more than one bit set
  always @(negedge clk) begin
    nChecks++;
    if (!$onehot0(grt)) begin
      nFails++;
      $display("[TB] FAIL onehot: grt=%b has multiple bits set", grt);
    end
  end

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    nChecks++;
    if (act !== exp) begin
      nFails++;
      $display("[TB] FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic applyStimulus(input logic r, input logic [N-1:0] q);
    rst      = r;
    req      = q;
    memRdata = $urandom;
    step();
  endtask

  // Expected bus values derive from the expected grant and the bench's own master tables
  task automatic checkAll(input string tag, input logic [N-1:0] expGrt, input logic inRst);
    logic [AW-1:0] eAddr;
    logic [DW-1:0] eWdata;
    logic [MW-1:0] eWdm;
    logic [MW-1:0] eRdm;
    eAddr = '0; eWdata = '0; eWdm = '0; eRdm = '0;
    for (int i = 0; i < N; i++) begin
      if (expGrt[i] && !inRst) begin
        eAddr = refAddr[i]; eWdata = refWdata[i]; eWdm = refWdm[i]; eRdm = refRdm[i];
      end
    end
    checkOutput({tag, " grt"},   32'(grt),      32'(expGrt));
    checkOutput({tag, " busy"},  32'(busy),     32'(|expGrt));
    checkOutput({tag, " addr"},  32'(memAddr),  32'(eAddr));
    checkOutput({tag, " wdata"}, 32'(memWdata), 32'(eWdata));
    checkOutput({tag, " wdm"},   32'(memWdm),   32'(eWdm));
    checkOutput({tag, " rdm"},   32'(memRdm),   32'(eRdm));
    checkOutput({tag, " rdata"}, 32'(mRdata),   32'(memRdata));
  endtask

  initial begin
    logic [N-1:0] expTo [6];
    logic [N-1:0] expSat [3];

    for (int i = 0; i < N; i++) begin
      refAddr[i]  = 32'hA000_0000 + 32'(i) * 32'h111;
      refWdata[i] = 32'h5000_0000 | 32'(i + 7);
      refWdm[i]   = 2'((i % 3) + 1);
      refRdm[i]   = 2'(3 - (i % 3));
      mAddr[i*AW +: AW]  = refAddr[i];
      mWdata[i*DW +: DW] = refWdata[i];
      mWdm[i*MW +: MW]   = refWdm[i];
      mRdm[i*MW +: MW]   = refRdm[i];
    end
    rst = 1'b1; req = '0; memRdata = '0;

    vecs[0]  = '{1'b1, 4'b0000, 4'b0000};
    vecs[1]  = '{1'b0, 4'b0001, 4'b0001};
    vecs[2]  = '{1'b0, 4'b0001, 4'b0001};
    vecs[3]  = '{1'b0, 4'b0000, 4'b0000};
    vecs[4]  = '{1'b1, 4'b1111, 4'b0000};
    vecs[5]  = '{1'b0, 4'b1111, 4'b0001};
    vecs[6]  = '{1'b0, 4'b1111, 4'b0001};
    vecs[7]  = '{1'b0, 4'b1110, 4'b0010};
    vecs[8]  = '{1'b0, 4'b1110, 4'b0010};
    vecs[9]  = '{1'b0, 4'b1100, 4'b0100};
    vecs[10] = '{1'b0, 4'b1100, 4'b0100};
    vecs[11] = '{1'b0, 4'b1000, 4'b1000};
    vecs[12] = '{1'b0, 4'b1000, 4'b1000};
    vecs[13] = '{1'b0, 4'b0000, 4'b0000};
    vecs[14] = '{1'b0, 4'b0100, 4'b0100};
    vecs[15] = '{1'b0, 4'b1110, 4'b0100};
    vecs[16] = '{1'b0, 4'b1010, 4'b1000};
    vecs[17] = '{1'b0, 4'b0010, 4'b0010};
    vecs[18] = '{1'b0, 4'b0000, 4'b0000};
    vecs[19] = '{1'b0, 4'b0100, 4'b0100};
    vecs[20] = '{1'b1, 4'b0100, 4'b0000};
    vecs[21] = '{1'b0, 4'b1111, 4'b0001};
    vecs[22] = '{1'b0, 4'b0000, 4'b0000};

    step();
    for (int k = 0; k < 23; k++) begin
      applyStimulus(vecs[k].rst, vecs[k].req);
      checkAll($sformatf("v%0d", k), vecs[k].expGrt, vecs[k].rst);
    end

    // Reset cycle with a live grant must present an idle bus
    applyStimulus(1'b0, 4'b0100);
    rst = 1'b1;
    #1;
    checkOutput("rstIdle wdm", 32'(memWdm), 32'd0);
    checkOutput("rstIdle rdm", 32'(memRdm), 32'd0);
    step();
    checkOutput("rstIdle grt", 32'(grt), 32'd0);

`ifdef MEM_ARB_TIMEOUT_EN
    expTo  = '{4'b0001, 4'b0001, 4'b0001, 4'b0001, 4'b0000, 4'b0010};
    expSat = '{4'b0000, 4'b0010, 4'b0010};
`else
    expTo  = '{4'b0001, 4'b0001, 4'b0001, 4'b0001, 4'b0001, 4'b0001};
    expSat = '{4'b0001, 4'b0001, 4'b0001};
`endif

    // Master 0 holds while master 1 waits
    applyStimulus(1'b1, 4'b0000);
    applyStimulus(1'b0, 4'b0001);
    checkAll("to0", expTo[0], 1'b0);
    for (int c = 1; c < 6; c++) begin
      applyStimulus(1'b0, 4'b0011);
      checkAll($sformatf("to%0d", c), expTo[c], 1'b0);
    end

    // Sole requester keeps the bus past MAX_HOLD, then yields once a rival appears
    applyStimulus(1'b1, 4'b0000);
    for (int c = 0; c < 6; c++) begin
      applyStimulus(1'b0, 4'b0001);
      checkAll($sformatf("sat%0d", c), 4'b0001, 1'b0);
    end
    for (int c = 0; c < 3; c++) begin
      applyStimulus(1'b0, 4'b0011);
      checkAll($sformatf("satRival%0d", c), expSat[c], 1'b0);
    end

    applyStimulus(1'b0, 4'b0000);
    $display("[TB] %0d tests run, %0d failed", nChecks, nFails);
    $finish;
  end

endmodule
